alu_issue_stage: RTL and testbench

- Upstream issue/retire stage for the 4-bit combinational ALU datapath (add/sub/pass-a/pass-b).
- Buffers operand+opcode requests in a small FIFO and drives the ALU operand inputs from registered state.
- Captures the ALU result into an output register with a valid/ready handshake, so a purely combinational ALU sits between two flop boundaries.
- Also keeps a wrap-around retire counter for debug/perf readout.

---
 rtl/alu_pkg.sv | 13 +
 rtl/alu_req_fifo.sv | 36 +++
 rtl/alu_issue_stage.sv | 69 ++++++
 tb/tb_alu_issue_stage.sv | 200 ++++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// alu_pkg: shared ALU width, opcode encoding and request record for the issue stage
package alu_pkg;
    localparam int ALU_W = 4;
    localparam logic [1:0] OP_ADD   = 2'b00;
    localparam logic [1:0] OP_SUB   = 2'b01;
    localparam logic [1:0] OP_PASSA = 2'b10;
    localparam logic [1:0] OP_PASSB = 2'b11;
    typedef struct packed {
        logic [ALU_W-1:0] a;
        logic [ALU_W-1:0] b;
        logic [1:0]       opcode;
    } alu_req_t;
endpackage

// File: rtl/alu_req_fifo.sv
// alu_req_fifo: small power-of-two request FIFO with registered head and occupancy count
module alu_req_fifo
    import alu_pkg::*;
#(
    parameter int DEPTH = 2,
    parameter int W     = $bits(alu_req_t)
) (
    input  logic                         clock,
    input  logic                         reset_n,
    input  logic                         push,
    input  logic                         pop,
    input  logic [W-1:0]                 wdata,
    output logic [W-1:0]                 head,
    output logic [$clog2(DEPTH+1)-1:0]   count
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH+1);
    logic [W-1:0]  mem [DEPTH];
    logic [PW-1:0] wr_ptr, rd_ptr;
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + PW'(1);
            if (pop) rd_ptr <= rd_ptr + PW'(1);
            count <= count + CW'(push) - CW'(pop);
        end
    end
    // storage needs no reset: the head is only observed while count is nonzero
    always_ff @(posedge clock) begin
        if (push) mem[wr_ptr] <= wdata;
    end
    assign head = mem[rd_ptr];
endmodule

// File: rtl/alu_issue_stage.sv
// alu_issue_stage: buffers ALU requests, drives the ALU from flops and registers its result
module alu_issue_stage
    import alu_pkg::*;
#(
    parameter int DATA_W = ALU_W,
    parameter int DEPTH  = 2,
    parameter int CNT_W  = 8
) (
    input  logic              clock,
    input  logic              reset_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_a,
    input  logic [DATA_W-1:0] in_b,
    input  logic [1:0]        in_opcode,
    output logic [DATA_W-1:0] alu_a,
    output logic [DATA_W-1:0] alu_b,
    output logic [1:0]        alu_opcode,
    input  logic [DATA_W-1:0] alu_out,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_result,
    output logic [1:0]        out_opcode,
    output logic              out_zero,
    output logic [CNT_W-1:0]  retire_cnt
);
    localparam int CW = $clog2(DEPTH+1);
    alu_req_t        req, head;
    logic [CW-1:0]   count;
    logic            nonempty, push, issue, accept;
    assign req      = '{a: in_a, b: in_b, opcode: in_opcode};
    assign nonempty = count != '0;
    assign in_ready = count != CW'(DEPTH);
    assign push     = in_valid & in_ready;
    assign issue    = nonempty & (!out_valid | out_ready);
    assign accept   = out_valid & out_ready;
    // ALU inputs come only from queued state, never from in_*
    assign alu_a      = nonempty ? head.a : '0;
    assign alu_b      = nonempty ? head.b : '0;
    assign alu_opcode = nonempty ? head.opcode : '0;
    alu_req_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clock   (clock),
        .reset_n (reset_n),
        .push    (push),
        .pop     (issue),
        .wdata   (req),
        .head    (head),
        .count   (count)
    );
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            out_valid  <= 1'b0;
            out_result <= '0;
            out_opcode <= '0;
            out_zero   <= 1'b0;
            retire_cnt <= '0;
        end else begin
            if (issue) begin
                out_valid  <= 1'b1;
                out_result <= alu_out;
                out_opcode <= head.opcode;
                out_zero   <= alu_out == '0;
            end else if (accept) begin
                out_valid <= 1'b0;
            end
            if (accept) retire_cnt <= retire_cnt + CNT_W'(1);
        end
    end
endmodule

// File: tb/tb_alu_issue_stage.sv
// tb_alu_issue_stage: scoreboard bench for alu_issue_stage with a behavioural ALU in the loop
`timescale 1ns/1ps
module tb_alu_issue_stage;
    import alu_pkg::*;
    logic       clock = 0, reset_n = 1, in_valid = 0, out_ready = 0;
    logic [3:0] in_a = 0, in_b = 0;
    logic [1:0] in_opcode = 0;
    logic       in_ready, out_valid, out_zero;
    logic [3:0] alu_a, alu_b, alu_out, out_result;
    logic [1:0] alu_opcode, out_opcode;
    logic [7:0] retire_cnt;
    int total = 0, passed = 0;
    typedef struct packed {logic [3:0] r; logic [1:0] op; logic z;} res_t;
    res_t sb[$];

    always #5 clock = ~clock;

    always_comb begin
        case (alu_opcode)
            2'b00:   alu_out = alu_a + alu_b;
            2'b01:   alu_out = alu_a - alu_b;
            2'b10:   alu_out = alu_a;
            default: alu_out = alu_b;
        endcase
    end

    alu_issue_stage dut (
        .clock      (clock),
        .reset_n    (reset_n),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_a       (in_a),
        .in_b       (in_b),
        .in_opcode  (in_opcode),
        .alu_a      (alu_a),
        .alu_b      (alu_b),
        .alu_opcode (alu_opcode),
        .alu_out    (alu_out),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_result (out_result),
        .out_opcode (out_opcode),
        .out_zero   (out_zero),
        .retire_cnt (retire_cnt)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    function automatic res_t model(input logic [3:0] a, input logic [3:0] b, input logic [1:0] op);
        logic [3:0] r;
        r = op == OP_ADD ? a + b : op == OP_SUB ? a - b : op == OP_PASSA ? a : b;
        return '{r: r, op: op, z: r == 4'd0};
    endfunction

    // monitor: a result presented with out_ready high is consumed at the next edge
    always @(negedge clock) begin
        if (reset_n && out_valid && out_ready) begin
            if (sb.size() == 0) begin
                total++;
                $display("FAIL unexpected_result: got %0h expected none", out_result);
            end else begin
                chk("result", {out_result, out_opcode, out_zero}, sb.pop_front());
            end
        end
    end

    task automatic cyc(input int n);
        repeat (n) begin
            @(posedge clock);
            #1;
        end
    endtask

    task automatic push_op(input logic [3:0] a, input logic [3:0] b, input logic [1:0] op);
        int n = 0;
        in_valid = 1; in_a = a; in_b = b; in_opcode = op;
        @(negedge clock);
        while (!in_ready && n < 50) begin
            @(negedge clock);
            n++;
        end
        if (!in_ready) begin
            total++;
            $display("FAIL push_timeout: got in_ready=0 expected 1");
        end else sb.push_back(model(a, b, op));
        @(posedge clock);
        #1;
    endtask

    task automatic stream(input int n);
        for (int i = 0; i < n; i++)
            push_op(4'($urandom), 4'($urandom), 2'($urandom));
        in_valid = 0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        #1 reset_n = 0;
        in_valid = 1; in_a = 7; in_b = 7; in_opcode = 2'b11;
        #2;
        chk("rst_in_ready", in_ready, 1);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_retire", retire_cnt, 0);
        chk("rst_alu", {alu_a, alu_b, alu_opcode}, 0);
        repeat (2) @(posedge clock);
        #1;
        chk("rst_hold_out_valid", out_valid, 0);
        chk("rst_hold_alu", {alu_a, alu_b, alu_opcode}, 0);
        in_valid = 0; reset_n = 1; out_ready = 1;
        cyc(3);
        chk("idle_out_valid", out_valid, 0);
        chk("idle_in_ready", in_ready, 1);
        chk("idle_retire", retire_cnt, 0);
        chk("idle_alu", {alu_a, alu_b, alu_opcode}, 0);

        push_op(4'd3, 4'd5, OP_ADD);
        in_valid = 0;
        chk("lat_e0_valid", out_valid, 0);
        chk("alu_drive", {alu_a, alu_b, alu_opcode}, {4'd3, 4'd5, 2'b00});
        cyc(1);
        chk("lat_e1_valid", out_valid, 1);
        chk("single_result", {out_result, out_opcode, out_zero}, {4'd8, 2'b00, 1'b0});
        cyc(1);
        chk("single_retire", retire_cnt, 1);

        push_op(4'd4, 4'd4, OP_SUB);
        push_op(4'd2, 4'd15, OP_ADD);
        in_valid = 0;
        cyc(3);
        chk("wrap_retire", retire_cnt, 3);

        out_ready = 0;
        push_op(4'd9, 4'd6, OP_PASSA);
        push_op(4'd9, 4'd6, OP_PASSB);
        push_op(4'd1, 4'd2, OP_ADD);
        in_valid = 0;
        chk("bp_in_ready", in_ready, 0);
        chk("bp_out_valid", out_valid, 1);
        chk("bp_first", {out_result, out_opcode, out_zero}, {4'd9, 2'b10, 1'b0});
        cyc(3);
        chk("bp_held", {out_result, out_opcode, out_zero}, {4'd9, 2'b10, 1'b0});
        chk("bp_held_ready", in_ready, 0);
        chk("bp_held_retire", retire_cnt, 3);
        out_ready = 1;
        cyc(3);
        chk("bp_drain_retire", retire_cnt, 6);
        chk("bp_drain_ready", in_ready, 1);
        chk("bp_drain_valid", out_valid, 0);

        stream(20);
        cyc(2);
        chk("stream_retire", retire_cnt, 26);
        chk("stream_done_valid", out_valid, 0);

        out_ready = 0;
        push_op(4'd1, 4'd1, OP_ADD);
        push_op(4'd2, 4'd2, OP_ADD);
        push_op(4'd3, 4'd3, OP_ADD);
        in_valid = 0;
        chk("mid_full", {in_ready, out_valid}, 2'b01);
        #1 reset_n = 0;
        #1;
        chk("mid_out_valid", out_valid, 0);
        chk("mid_in_ready", in_ready, 1);
        chk("mid_regs", {out_result, out_opcode, out_zero, retire_cnt}, 0);
        chk("mid_alu", {alu_a, alu_b, alu_opcode}, 0);
        sb.delete();
        #1 reset_n = 1;
        out_ready = 1;
        @(posedge clock);
        #1;
        push_op(4'd5, 4'd1, OP_SUB);
        in_valid = 0;
        cyc(3);
        chk("post_rst_retire", retire_cnt, 1);
        chk("post_rst_valid", out_valid, 0);
        chk("post_rst_sb_empty", sb.size(), 0);

        stream(254);
        cyc(2);
        chk("cnt_max", retire_cnt, 255);
        push_op(4'd0, 4'd0, OP_PASSB);
        in_valid = 0;
        cyc(2);
        chk("cnt_wrap", retire_cnt, 0);
        chk("final_sb_empty", sb.size(), 0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
